cp0_exc_ctrl: RTL and testbench

//  Exception/ERET sequencer between the WB stage and the CP0 register file.
//  - Arbitrates the WB-stage exception, ERET and (optionally) interrupt events.
//  - Drives CP0 commit strobes: wb_ex, wb_excode, wb_bd, wb_pc, eret_flush.
//  - Holds a pipeline-wide flush, then hands a redirect PC to fetch under a valid/ready handshake.

---
 rtl/cp0_exc_ctrl.sv | 115 +++++++++++
 tb/tb_cp0_exc_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: WB-stage exception/ERET sequencer driving CP0 commit strobes, flush and fetch redirect.
// Define CP0_EXC_INT_EN to let pending enabled interrupts preempt the WB instruction.
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          MIN_FLUSH  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_valid,
    output logic        ws_ready,
    input  logic        ws_ex,
    input  logic [4:0]  ws_excode,
    input  logic        ws_bd,
    input  logic [31:0] ws_pc,
    input  logic        ws_eret,
    input  logic [31:0] c0_status,
    input  logic [31:0] c0_cause,
    input  logic [31:0] c0_epc,
    output logic        wb_ex,
    output logic [4:0]  wb_excode,
    output logic        wb_bd,
    output logic [31:0] wb_pc,
    output logic        eret_flush,
    output logic        flush_all,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_COMMIT   = 2'd1;
    localparam logic [1:0] S_FLUSH    = 2'd2;
    localparam logic [1:0] S_REDIRECT = 2'd3;
    localparam int CW = (MIN_FLUSH > 1) ? $clog2(MIN_FLUSH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MIN_FLUSH - 1);

    logic [1:0]    state_q, state_d;
    logic          ex_q, ex_d;
    logic [4:0]    excode_q, excode_d;
    logic          bd_q, bd_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   target_q, target_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          int_pend, ev, commit;
    logic          unused_ok;

`ifdef CP0_EXC_INT_EN
    assign int_pend = c0_status[0] & ~c0_status[1] & |(c0_cause[15:8] & c0_status[15:8]);
`else
    assign int_pend = 1'b0;
`endif
    assign unused_ok = ^{c0_status, c0_cause};

    assign ev     = ws_valid & (int_pend | ws_ex | ws_eret);
    assign commit = state_q == S_COMMIT;

    always_comb begin
        state_d  = state_q;
        ex_d     = ex_q;
        excode_d = excode_q;
        bd_d     = bd_q;
        pc_d     = pc_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: if (ev) begin
                state_d  = S_COMMIT;
                ex_d     = int_pend | ws_ex;
                excode_d = int_pend ? 5'h00 : ws_excode;
                bd_d     = ws_bd;
                pc_d     = ws_pc;
            end
            S_COMMIT: begin
                state_d  = S_FLUSH;
                cnt_d    = CNT_INIT;
                target_d = ex_q ? EXC_VECTOR : c0_epc;
            end
            S_FLUSH: begin
                cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
                state_d = (cnt_q <= CW'(1)) ? S_REDIRECT : S_FLUSH;
            end
            default: state_d = redirect_ready ? S_IDLE : S_REDIRECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ex_q     <= 1'b0;
            excode_q <= '0;
            bd_q     <= 1'b0;
            pc_q     <= '0;
            target_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ex_q     <= ex_d;
            excode_q <= excode_d;
            bd_q     <= bd_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

    // Commit payload is gated to the COMMIT cycle so CP0 never sees stale values.
    assign ws_ready       = state_q == S_IDLE;
    assign wb_ex          = commit & ex_q;
    assign wb_excode      = wb_ex ? excode_q : 5'h00;
    assign wb_bd          = wb_ex & bd_q;
    assign wb_pc          = wb_ex ? pc_q : 32'h0;
    assign eret_flush     = commit & ~ex_q;
    assign flush_all      = state_q != S_IDLE;
    assign redirect_valid = state_q == S_REDIRECT;
    assign redirect_pc    = redirect_valid ? target_q : 32'h0;
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed checks of the exception/ERET sequencer with default parameters.
module tb_cp0_exc_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        ws_valid, ws_ready, ws_ex, ws_bd, ws_eret;
    logic [4:0]  ws_excode, wb_excode;
    logic [31:0] ws_pc, c0_status, c0_cause, c0_epc, wb_pc, redirect_pc;
    logic        wb_ex, wb_bd, eret_flush, flush_all, redirect_valid, redirect_ready;
    int          errors = 0;
    int          checks = 0;
    int          n;
    logic        seen;

    cp0_exc_ctrl dut (
        .clk(clk), .reset(reset), .ws_valid(ws_valid), .ws_ready(ws_ready),
        .ws_ex(ws_ex), .ws_excode(ws_excode), .ws_bd(ws_bd), .ws_pc(ws_pc),
        .ws_eret(ws_eret), .c0_status(c0_status), .c0_cause(c0_cause), .c0_epc(c0_epc),
        .wb_ex(wb_ex), .wb_excode(wb_excode), .wb_bd(wb_bd), .wb_pc(wb_pc),
        .eret_flush(eret_flush), .flush_all(flush_all), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_ws();
        ws_valid = 0; ws_ex = 0; ws_eret = 0; ws_bd = 0; ws_excode = 0; ws_pc = 0;
    endtask

    initial begin
        reset = 1; clear_ws(); redirect_ready = 0;
        c0_status = 0; c0_cause = 0; c0_epc = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("rst_ws_ready", ws_ready, 1);
        chk("rst_outs", {wb_ex, eret_flush, flush_all, redirect_valid}, 0);
        chk("rst_redirect_pc", redirect_pc, 0);

        // exception commit, flush, redirect to the vector
        ws_valid = 1; ws_ex = 1; ws_excode = 5'h0C; ws_pc = 32'hBFC0_0100; ws_bd = 0;
        @(negedge clk);
        chk("t1_wb_ex", wb_ex, 1);
        chk("t1_excode", wb_excode, 5'h0C);
        chk("t1_pc", wb_pc, 32'hBFC0_0100);
        chk("t1_bd", wb_bd, 0);
        chk("t1_commit_flags", {eret_flush, flush_all, ws_ready, redirect_valid}, 4'b0100);
        clear_ws();
        @(negedge clk);
        chk("t1_flush", {wb_ex, flush_all, redirect_valid}, 3'b010);
        @(negedge clk);
        chk("t1_rv", redirect_valid, 1);
        chk("t1_rpc", redirect_pc, 32'hBFC0_0380);
        chk("t1_flush_redirect", flush_all, 1);
        redirect_ready = 1;
        @(negedge clk);
        chk("t1_idle", {ws_ready, flush_all, redirect_valid}, 3'b100);
        redirect_ready = 0;

        // ERET with fetch stalling three cycles; EPC changes after commit must not leak
        c0_epc = 32'hBFC0_1234; ws_valid = 1; ws_eret = 1;
        @(negedge clk);
        chk("t2_eret_flush", eret_flush, 1);
        chk("t2_no_wb_ex", wb_ex, 0);
        clear_ws();
        @(negedge clk);
        c0_epc = 32'h1111_2222;
        chk("t2_eret_once", eret_flush, 0);
        for (int i = 0; i < 4; i++) begin
            redirect_ready = (i == 3);
            @(negedge clk);
            chk($sformatf("t2_rv_%0d", i), redirect_valid, (i < 3) ? 1 : 0);
            if (i < 3) chk($sformatf("t2_rpc_%0d", i), redirect_pc, 32'hBFC0_1234);
        end
        chk("t2_idle", ws_ready, 1);
        redirect_ready = 0;

        // ex and eret together; redirect_ready held high early is ignored until valid
        ws_valid = 1; ws_ex = 1; ws_eret = 1; ws_excode = 5'h0A; ws_pc = 32'h8000_0040; ws_bd = 1;
        redirect_ready = 1;
        @(negedge clk);
        chk("t3_wb_ex", wb_ex, 1);
        chk("t3_excode", wb_excode, 5'h0A);
        chk("t3_bd", wb_bd, 1);
        chk("t3_no_eret", eret_flush, 0);
        clear_ws();
        @(negedge clk);
        chk("t3_no_early_accept", flush_all, 1);
        @(negedge clk);
        chk("t3_rv", redirect_valid, 1);
        chk("t3_rpc", redirect_pc, 32'hBFC0_0380);
        @(negedge clk);
        chk("t3_idle", ws_ready, 1);
        redirect_ready = 0;

        // interrupt preemption (only when enabled) vs plain exception
        c0_status = 32'h0000_0101; c0_cause = 32'h0000_0100;
        ws_valid = 1; ws_ex = 1; ws_excode = 5'h08; ws_pc = 32'hBFC0_0200;
        @(negedge clk);
`ifdef CP0_EXC_INT_EN
        chk("t4_int_excode", wb_excode, 5'h00);
`else
        chk("t4_noint_excode", wb_excode, 5'h08);
`endif
        chk("t4_pc", wb_pc, 32'hBFC0_0200);
        clear_ws(); redirect_ready = 1;
        repeat (3) @(negedge clk);
        chk("t4_idle_a", ws_ready, 1);
        redirect_ready = 0; c0_status = 32'h0000_0103;
        ws_valid = 1; ws_ex = 1; ws_excode = 5'h08;
        @(negedge clk);
        chk("t4_exl_excode", wb_excode, 5'h08);
        clear_ws(); redirect_ready = 1;
        repeat (3) @(negedge clk);
        chk("t4_idle_b", ws_ready, 1);
        redirect_ready = 0; c0_status = 0; c0_cause = 0;

        // reset during FLUSH aborts the sequence
        ws_valid = 1; ws_ex = 1; ws_excode = 5'h04;
        @(negedge clk);
        clear_ws();
        @(negedge clk);
        chk("t5_in_flush", {flush_all, redirect_valid}, 2'b10);
        reset = 1; redirect_ready = 1;
        @(negedge clk);
        chk("t5_rst_outs", {wb_ex, eret_flush, flush_all, redirect_valid}, 0);
        chk("t5_rst_ready", ws_ready, 1);
        chk("t5_rst_rpc", redirect_pc, 0);
        reset = 0; seen = 0;
        repeat (5) begin
            @(negedge clk);
            seen |= redirect_valid | flush_all | wb_ex | eret_flush;
        end
        chk("t5_quiet", seen, 0);
        redirect_ready = 0;

        // events held during FLUSH/REDIRECT are ignored
        ws_valid = 1; ws_ex = 1; ws_excode = 5'h0D; ws_pc = 32'hBFC0_0300; n = 0;
        repeat (4) begin
            @(negedge clk);
            n += int'(wb_ex);
        end
        chk("t6_single_wb_ex", n, 1);
        chk("t6_still_redirect", redirect_valid, 1);
        clear_ws(); redirect_ready = 1;
        @(negedge clk);
        chk("t6_idle", {ws_ready, wb_ex}, 2'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
